// File: rtl/sram_arb_pkg.sv
// Shared types and static tie-off constants for the single-port SRAM arbiter.
package sram_arb_pkg;

  localparam int SRAM_AW = 9;
  localparam int SRAM_DW = 8;

  localparam logic [2:0] EMA_DEF   = 3'b010;
  localparam logic       STOV_VAL  = 1'b0;
  localparam logic [1:0] EMAW_VAL  = 2'b01;
  localparam logic       EMAS_VAL  = 1'b0;
  localparam logic       WABL_VAL  = 1'b0;
  localparam logic [1:0] WABLM_VAL = 2'b01;
  localparam logic       RET1N_VAL = 1'b1;

  typedef logic port_id_t;
  localparam port_id_t PORT_R0 = 1'b0;
  localparam port_id_t PORT_R1 = 1'b1;

  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } req_t;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/sram_arb_rspbuf.sv
// Per-port read-response FIFO plus the read credit counter that keeps it from overflowing.
module sram_arb_rspbuf
  import sram_arb_pkg::*;
#(
  parameter int DW        = SRAM_DW,
  parameter int RSP_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          rd_accept,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          credit_ok
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);

  logic [DW-1:0] mem_reg [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, credit_reg;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rsp_valid = (count_reg != '0);
  assign rsp_rdata = rsp_valid ? mem_reg[rd_ptr_reg] : '0;
  assign credit_ok = (credit_reg != '0);
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge CLK) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // A credit covers a read from accept until its response is consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      credit_reg <= CREDIT_MAX;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg  <= count_reg + CW'(push) - CW'(pop);
      credit_reg <= credit_reg - CW'(rd_accept) + CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) push |-> (count_reg < CREDIT_MAX));
  a_credit_max:  assert property (@(posedge CLK) disable iff (RST) credit_reg <= CREDIT_MAX);
  a_credit_use:  assert property (@(posedge CLK) disable iff (RST) rd_accept |-> credit_ok);

endmodule

// File: rtl/sram_sp_arbiter.sv
// Two-port round-robin arbiter in front of a registered single-port SRAM macro.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed r0-first priority.
module sram_sp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int         AW        = SRAM_AW,
  parameter int         DW        = SRAM_DW,
  parameter int         RSP_DEPTH = 2,
  parameter logic [2:0] EMA_VAL   = EMA_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic          r0_req_we,
  input  logic [AW-1:0] r0_req_addr,
  input  logic [DW-1:0] r0_req_wdata,
  output logic          r0_rsp_valid,
  input  logic          r0_rsp_ready,
  output logic [DW-1:0] r0_rsp_rdata,
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic          r1_req_we,
  input  logic [AW-1:0] r1_req_addr,
  input  logic [DW-1:0] r1_req_wdata,
  output logic          r1_rsp_valid,
  input  logic          r1_rsp_ready,
  output logic [DW-1:0] r1_rsp_rdata,
  output logic          sram_cen,
  output logic          sram_gwen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic          sram_stov,
  output logic [2:0]    sram_ema,
  output logic [1:0]    sram_emaw,
  output logic          sram_emas,
  output logic          sram_wabl,
  output logic [1:0]    sram_wablm,
  output logic          sram_ret1n
);

  logic [1:0]    req_valid, elig, gnt, rd_accept, push;
  logic [1:0]    rsp_valid, rsp_ready, credit_ok;
  logic [DW-1:0] rsp_rdata [2];
  req_t          req [2];
  req_t          sel;
  port_id_t      win;

  logic          cen_reg, gwen_reg;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] d_reg;
  logic          iss_rd_reg, cap_rd_reg;
  port_id_t      iss_port_reg, cap_port_reg;

  assign req_valid = {r1_req_valid, r0_req_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};
  assign req[0]    = '{we: r0_req_we, addr: r0_req_addr, wdata: r0_req_wdata};
  assign req[1]    = '{we: r1_req_we, addr: r1_req_addr, wdata: r1_req_wdata};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign elig[gi]      = req_valid[gi] & (req[gi].we | credit_ok[gi]);
      assign rd_accept[gi] = gnt[gi] & ~req[gi].we;
      assign push[gi]      = cap_rd_reg & (cap_port_reg == port_id_t'(gi));

      sram_arb_rspbuf #(.DW(DW), .RSP_DEPTH(RSP_DEPTH)) u_rspbuf (
        .CLK       (CLK),
        .RST       (RST),
        .rd_accept (rd_accept[gi]),
        .push      (push[gi]),
        .push_data (sram_q),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .credit_ok (credit_ok[gi])
      );
    end
  endgenerate

`ifdef ARB_FIXED_PRIO_EN
  assign gnt[0] = elig[0];
  assign gnt[1] = elig[1] & ~elig[0];
`else
  port_id_t rr_ptr_reg;

  assign gnt[0] = elig[0] & (~elig[1] | (rr_ptr_reg == PORT_R0));
  assign gnt[1] = elig[1] & (~elig[0] | (rr_ptr_reg == PORT_R1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       rr_ptr_reg <= PORT_R0;
    else if (|gnt) rr_ptr_reg <= other_port(win);
  end
`endif

  assign win          = gnt[1] ? PORT_R1 : PORT_R0;
  assign sel          = req[win];
  assign r0_req_ready = gnt[0];
  assign r1_req_ready = gnt[1];

  // The port/read tag travels two stages so it lines up with sram_q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cen_reg      <= 1'b0;
      gwen_reg     <= 1'b1;
      a_reg        <= '0;
      d_reg        <= '0;
      iss_rd_reg   <= 1'b0;
      iss_port_reg <= PORT_R0;
      cap_rd_reg   <= 1'b0;
      cap_port_reg <= PORT_R0;
    end else begin
      cen_reg <= |gnt;
      if (|gnt) begin
        gwen_reg <= ~sel.we;
        a_reg    <= sel.addr;
        d_reg    <= sel.wdata;
      end
      iss_rd_reg   <= (|gnt) & ~sel.we;
      iss_port_reg <= win;
      cap_rd_reg   <= iss_rd_reg;
      cap_port_reg <= iss_port_reg;
    end
  end

  assign sram_cen     = cen_reg;
  assign sram_gwen    = gwen_reg;
  assign sram_a       = a_reg;
  assign sram_d       = d_reg;
  assign r0_rsp_valid = rsp_valid[0];
  assign r1_rsp_valid = rsp_valid[1];
  assign r0_rsp_rdata = rsp_rdata[0];
  assign r1_rsp_rdata = rsp_rdata[1];

  assign sram_stov  = STOV_VAL;
  assign sram_ema   = EMA_VAL;
  assign sram_emaw  = EMAW_VAL;
  assign sram_emas  = EMAS_VAL;
  assign sram_wabl  = WABL_VAL;
  assign sram_wablm = WABLM_VAL;
  assign sram_ret1n = RET1N_VAL;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural 512x8 macro model.
module tb_sram_sp_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid, r0_rsp_ready;
  logic [8:0] r0_req_addr;
  logic [7:0] r0_req_wdata, r0_rsp_rdata;
  logic       r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid, r1_rsp_ready;
  logic [8:0] r1_req_addr;
  logic [7:0] r1_req_wdata, r1_rsp_rdata;
  logic       sram_cen, sram_gwen, sram_stov, sram_emas, sram_wabl, sram_ret1n;
  logic [8:0] sram_a;
  logic [7:0] sram_d, sram_q;
  logic [2:0] sram_ema;
  logic [1:0] sram_emaw, sram_wablm;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];

  logic [8:0] t2_a0 [4] = '{9'h001, 9'h002, 9'h003, 9'h004};
  logic [7:0] t2_e0 [4] = '{8'h5B, 8'h58, 8'h59, 8'h5E};
  logic [8:0] t2_a1 [4] = '{9'h120, 9'h121, 9'h122, 9'h123};
  logic [7:0] t2_e1 [4] = '{8'h7A, 8'h7B, 8'h78, 8'h79};
  logic [8:0] t3_a  [3] = '{9'h010, 9'h011, 9'h012};
  logic [7:0] t3_e  [3] = '{8'h4A, 8'h4B, 8'h48};

  always #5 CLK = ~CLK;

  sram_sp_arbiter dut (
    .CLK(CLK), .RST(RST),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .sram_stov(sram_stov), .sram_ema(sram_ema), .sram_emaw(sram_emaw),
    .sram_emas(sram_emas), .sram_wabl(sram_wabl), .sram_wablm(sram_wablm),
    .sram_ret1n(sram_ret1n)
  );

  // Macro model: unwritten locations read as addr[7:0]^0x5A.
  bit   [7:0] mem     [512];
  bit         written [512];
  logic [7:0] q_reg = 8'h00;
  assign sram_q = q_reg;

  always @(posedge CLK) begin
    if (sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a]     <= sram_d;
        written[sram_a] <= 1'b1;
      end else begin
        q_reg <= written[sram_a] ? mem[sram_a] : (sram_a[7:0] ^ 8'h5A);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] check %s: got 0x%0h ok", $time, tag, got);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && r0_rsp_valid && r0_rsp_ready) begin
      if (exp0_q.size() == 0) check("r0_rsp_unexp", 1, 0);
      else                    check("r0_rsp_data", r0_rsp_rdata, exp0_q.pop_front());
    end
    if (!RST && r1_rsp_valid && r1_rsp_ready) begin
      if (exp1_q.size() == 0) check("r1_rsp_unexp", 1, 0);
      else                    check("r1_rsp_data", r1_rsp_rdata, exp1_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  initial begin
    int i0, i1, j;
    r0_req_valid = 0; r0_req_we = 0; r0_req_addr = '0; r0_req_wdata = '0; r0_rsp_ready = 0;
    r1_req_valid = 0; r1_req_we = 0; r1_req_addr = '0; r1_req_wdata = '0; r1_rsp_ready = 0;
    repeat (2) tick();

    check("rst_cen", sram_cen, 0);
    check("rst_gwen", sram_gwen, 1);
    check("rst_a", sram_a, 0);
    check("rst_d", sram_d, 0);
    check("rst_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 0);
    check("rst_rdata", {r1_rsp_rdata, r0_rsp_rdata}, 0);
    check("tie_ema", sram_ema, 3'b010);
    check("tie_misc", {sram_stov, sram_emaw, sram_emas, sram_wabl, sram_wablm, sram_ret1n}, 8'b0_01_0_0_01_1);
    RST = 1'b0;
    tick();

    // write 0x3C to 0x1FF then read it back on r0
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 9'h1FF; r0_req_wdata = 8'h3C; r0_rsp_ready = 1;
    #1;
    check("t1_wr_rdy", {r1_req_ready, r0_req_ready}, 2'b01);
    tick();
    check("t1_wr_issue", {sram_cen, sram_gwen, sram_a, sram_d}, {1'b1, 1'b0, 9'h1FF, 8'h3C});
    r0_req_we = 0;
    #1;
    check("t1_rd_rdy", r0_req_ready, 1);
    exp0_q.push_back(8'h3C);
    tick();
    check("t1_rd_issue", {sram_cen, sram_gwen, sram_a}, {1'b1, 1'b1, 9'h1FF});
    r0_req_valid = 0;
    tick();
    check("t1_cen_off", sram_cen, 0);
    check("t1_rsp_early", r0_rsp_valid, 0);
    tick();
    check("t1_rsp_lat", r0_rsp_valid, 1);
    tick();
    check("t1_rsp_popped", r0_rsp_valid, 0);

`ifndef ARB_FIXED_PRIO_EN
    // continuous reads from both ports alternate r0,r1
    do_reset();
    r0_rsp_ready = 1; r1_rsp_ready = 1;
    r0_req_valid = 1; r0_req_we = 0; r1_req_valid = 1; r1_req_we = 0;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      r0_req_addr = t2_a0[i0 % 4];
      r1_req_addr = t2_a1[i1 % 4];
      #1;
      check("t2_r0_rdy", r0_req_ready, (k % 2) == 0);
      check("t2_r1_rdy", r1_req_ready, (k % 2) == 1);
      if (r0_req_ready && i0 < 4) begin exp0_q.push_back(t2_e0[i0]); i0++; end
      if (r1_req_ready && i1 < 4) begin exp1_q.push_back(t2_e1[i1]); i1++; end
      tick();
      check("t2_cen", sram_cen, 1);
    end
    r0_req_valid = 0; r1_req_valid = 0;
    repeat (4) tick();
`else
    // fixed priority: r1 starves while r0 stays eligible
    do_reset();
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 9'h080; r0_req_wdata = 8'h11;
    r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 9'h081; r1_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fp_r1_starve", {r1_req_ready, r0_req_ready}, 2'b01);
      tick();
    end
    r0_req_valid = 0;
    #1;
    check("fp_r1_grant", r1_req_ready, 1);
    exp1_q.push_back(8'hDB);
    tick();
    r1_req_valid = 0;
    repeat (4) tick();
`endif

    // r1 stalls its response channel: two reads in, third held off
    r1_rsp_ready = 0; r1_req_valid = 1; r1_req_we = 0;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      r1_req_addr = t3_a[j];
      #1;
      check("t3_rdy", r1_req_ready, c < 2);
      if (r1_req_ready && j < 2) begin exp1_q.push_back(t3_e[j]); j++; end
      tick();
    end
    check("t3_hold", {r1_rsp_valid, r1_rsp_rdata}, {1'b1, 8'h4A});
    r1_rsp_ready = 1;
    #1;
    check("t3_rdy_blk", r1_req_ready, 0);
    tick();
    check("t3_rdy_rel", r1_req_ready, 1);
    if (r1_req_ready) exp1_q.push_back(t3_e[2]);
    tick();
    r1_req_valid = 0;
    repeat (5) tick();

    // same-cycle r0 write / r1 read to 0x040 with pointer at r0
    do_reset();
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 9'h040; r0_req_wdata = 8'hA5;
    r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 9'h040; r1_rsp_ready = 1;
    #1;
    check("t4_first", {r1_req_ready, r0_req_ready}, 2'b01);
    tick();
    r0_req_valid = 0;
    #1;
    check("t4_second", r1_req_ready, 1);
    exp1_q.push_back(8'hA5);
    tick();
    r1_req_valid = 0;
    repeat (4) tick();

    // reset one cycle after a read accept drops the read
    r0_rsp_ready = 1; r0_req_valid = 1; r0_req_we = 0; r0_req_addr = 9'h005;
    #1;
    check("t5_rd_rdy", r0_req_ready, 1);
    tick();
    r0_req_valid = 0;
    tick();
    RST = 1;
    #1;
    check("t5_rst_pins", {sram_cen, sram_gwen, sram_a, sram_d}, {1'b1 ^ 1'b1, 1'b1, 9'h000, 8'h00});
    check("t5_rst_rsp", {r1_rsp_valid, r0_rsp_valid, r1_rsp_rdata, r0_rsp_rdata}, 0);
    tick();
    RST = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_no_rsp", r0_rsp_valid, 0);
    end
    r0_rsp_ready = 0; r0_req_valid = 1; r0_req_we = 0;
    j = 0;
    for (int c = 0; c < 3; c++) begin
      r0_req_addr = 9'h006 + 9'(j);
      #1;
      check("t5_credit", r0_req_ready, c < 2);
      if (r0_req_ready && j < 2) begin exp0_q.push_back(8'h5C + 8'(j)); j++; end
      tick();
    end
    r0_req_valid = 0; r0_rsp_ready = 1;
    repeat (5) tick();

    check("q0_drained", exp0_q.size(), 0);
    check("q1_drained", exp1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
- Shares one single-port 512x8 SRAM macro between two requesters: r0 is the CPU load/store port, r1 is the loader/DMA port.
- Each requester port has a valid/ready request channel and a valid/ready read-response channel.
- Grants at most one SRAM access per cycle, round-robin, and drives the macro pins from registers.
- Buffers read data per port so a requester can stall its response channel without losing data.

Parameters:
- AW, 9, SRAM address width.
- DW, 8, SRAM data width.
- RSP_DEPTH, 2, per-port read-response buffer entries; also the per-port read credit limit.
- EMA_VAL, 3'b010, constant driven on sram_ema.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- rN_req_valid  in  1  request valid, N=0,1
- rN_req_ready  out  1  request accepted when valid&ready
- rN_req_we  in  1  1=write, 0=read
- rN_req_addr  in  AW  address
- rN_req_wdata  in  DW  write data
- rN_rsp_valid  out  1  read data available
- rN_rsp_ready  in  1  read data consumed
- rN_rsp_rdata  out  DW  read data
- sram_cen  out  1  macro enable, active-high
- sram_gwen  out  1  1=read, 0=write
- sram_a  out  AW  macro address
- sram_d  out  DW  macro write data
- sram_q  in  DW  macro read data; valid the cycle after the macro samples a read
- sram_stov, sram_ema, sram_emaw, sram_emas, sram_wabl, sram_wablm, sram_ret1n  out  1/3/2/1/1/2/1  static tie-offs:
  - 0, EMA_VAL, 2'b01, 0, 0, 2'b01, 1

Behaviour:
- Reset values:
  - all rsp_valid = 0; rsp_rdata = 0; sram_cen = 0; sram_gwen = 1; sram_a = 0; sram_d = 0.
  - RR pointer = r0; credits = RSP_DEPTH; response buffers empty.
- Eligibility: port N is eligible when req_valid and (req_we or credit_N > 0).
- Ready: rN_req_ready = eligible and granted. Both ready signals are never high in the same cycle.
- Grant:
  - Only one port eligible: that port wins.
  - Both eligible: the RR pointer port wins.
  - After any grant, the pointer moves to the other port. With no grant, the pointer holds.
- Issue stage (registered, edge E0 = accept):
  - sram_cen=1, gwen=~we, a=addr, d=wdata for one cycle.
  - The macro samples at E1.
  - With no accept, sram_cen=0 the next cycle.
- Read return:
  - The issue stage tags the port and read flag, and the tag is pipelined one stage.
  - sram_q is written into port N's buffer at E2. rsp_valid is high after E2.
  - Read latency from accept to rsp_valid is 2 cycles.
  - Back-to-back accepts each cycle are supported.
- Writes produce no response and consume no credit.
- Credits:
  - Decrement on read accept; increment on rsp handshake.
  - Same-cycle accept and handshake leaves the credit unchanged.
  - Credits never exceed RSP_DEPTH, so the buffer never overflows. Overflow would be a design error; assert it.
- Response buffer:
  - FIFO order per port. rsp_rdata = head entry.
  - Capture and pop in the same cycle are allowed.
- Ordering: accesses are serialised in grant order. A read granted after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads and buffered data are dropped; all state returns to reset values immediately.

Optional Feature:
- ARB_FIXED_PRIO_EN.
- Defined:
  - r0 wins every contention; the RR pointer is removed.
  - r1 is granted only when r0 is not eligible.
- Undefined: round-robin as above.

Decomposition:
- Package sram_arb_pkg holds:
  - AW/DW defaults and the tie-off constants;
  - a req_t struct (we, addr, wdata) and a port-id typedef.
- One sub-module, sram_arb_rspbuf: the per-port RSP_DEPTH FIFO with credit counter, instantiated twice.

Test Plan:
- Reset, then r0 writes 0x3C to addr 0x1FF, then r0 reads 0x1FF with rsp_ready=1:
  - sram_cen pulses once per accept;
  - r0_rsp_valid is high 2 cycles after the read accept with rdata=0x3C.
- r0 and r1 both issue reads continuously:
  - grants alternate r0,r1,r0,r1;
  - sram_cen is high every cycle;
  - each port gets data in order.
- r1_rsp_ready=0 while r1 issues reads to 0x010, 0x011, 0x012:
  - two reads are accepted, then r1_req_ready stays 0;
  - after rsp_ready=1, data pops in order, then the third read is accepted.
- Same cycle, r0 writes 0xA5 to 0x040 and r1 reads 0x040 with the pointer at r0:
  - r1 returns 0xA5.
- RST asserted one cycle after a read accept:
  - no rsp_valid follows;
  - all outputs are at reset values;
  - credits are restored.
- With ARB_FIXED_PRIO_EN and r0 always valid:
  - r1_req_ready stays 0;
  - when r0 drops valid, r1 is granted the next cycle.
